// File: rtl/sd_init_seq.sv
// sd_init_seq: SD card SPI-mode power-up and initialisation sequencer.
// Runs CMD0, CMD8, CMD55/ACMD41 and CMD16, then serves single-word CMD17 reads.
// It drives the downstream sd_cmd engine's command fields and start strobe.
module sd_init_seq #(
    parameter int unsigned POWERUP_CYCLES = 80,
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned CMD_TIMEOUT    = 2048,
    parameter int unsigned CMD0_RETRIES   = 8,
    parameter int unsigned ACMD41_RETRIES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init_start,
    input  logic        read_req,
    input  logic [31:0] read_addr,
    output logic        ready,
    output logic        busy,
    output logic        error,
    output logic [3:0]  error_code,
    output logic [31:0] read_data,
    output logic        read_valid,
    output logic        cs_n,
    output logic [7:0]  cmd_number,
    output logic [31:0] cmd_args,
    output logic [7:0]  cmd_crc,
    output logic        cmd_start,
    input  logic        cmd_done,
    input  logic [7:0]  cmd_resp,
    input  logic [31:0] cmd_data
);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_POWERUP = 4'd1,
        ST_CMD0    = 4'd2,
        ST_CMD8    = 4'd3,
        ST_CMD55   = 4'd4,
        ST_ACMD41  = 4'd5,
        ST_CMD16   = 4'd6,
        ST_READY   = 4'd7,
        ST_READ    = 4'd8,
        ST_ERROR   = 4'd9
    } state_t;

    localparam logic [15:0] PU_LAST   = 16'(POWERUP_CYCLES - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] WD_LAST   = 16'(CMD_TIMEOUT - 1);
    localparam logic [7:0]  CMD0_LAST = 8'(CMD0_RETRIES - 1);
    localparam logic [7:0]  PAIR_LAST = 8'(ACMD41_RETRIES - 1);

    localparam logic [3:0] ERR_NONE    = 4'd0;
    localparam logic [3:0] ERR_CMD0    = 4'd1;
    localparam logic [3:0] ERR_CMD8    = 4'd2;
    localparam logic [3:0] ERR_ACMD41  = 4'd3;
    localparam logic [3:0] ERR_CMD16   = 4'd4;
    localparam logic [3:0] ERR_READ    = 4'd5;
    localparam logic [3:0] ERR_TIMEOUT = 4'd6;

    state_t      state_r;
    logic [15:0] timer_r;      // power-up window and inter-command gap
    logic [15:0] wd_cnt_r;     // cycles since cmd_start rose
    logic [7:0]  cmd0_cnt_r;   // CMD0 attempts already failed
    logic [7:0]  pair_cnt_r;   // CMD55/ACMD41 pairs answered "still idle"
    logic [31:0] addr_r;       // latched CMD17 argument

    state_t      done_next_s;
    logic [3:0]  done_code_s;

    // Fixed command byte / argument / CRC for each command-issuing state
    function automatic logic [47:0] cmd_fields(input state_t st, input logic [31:0] addr);
        logic [47:0] f;
        case (st)
            ST_CMD0:   f = {8'h40, 32'h0000_0000, 8'h95};
            ST_CMD8:   f = {8'h48, 32'h0000_01AA, 8'h87};
            ST_CMD55:  f = {8'h77, 32'h0000_0000, 8'hFF};
            ST_ACMD41: f = {8'h69, 32'h4000_0000, 8'hFF};
            ST_CMD16:  f = {8'h50, 32'h0000_0004, 8'hFF};
            ST_READ:   f = {8'h51, addr,          8'hFF};
            default:   f = 48'h0000_0000_0000;
        endcase
        return f;
    endfunction

    // Judge the engine response of the current command: where to go next, or why to fail
    always_comb begin
        done_next_s = ST_ERROR;
        done_code_s = ERR_NONE;
        case (state_r)
            ST_CMD0: begin
                if (cmd_resp == 8'h01) begin
                    done_next_s = ST_CMD8;
                end else if (cmd0_cnt_r == CMD0_LAST) begin
                    done_code_s = ERR_CMD0;
                end else begin
                    done_next_s = ST_CMD0;
                end
            end
            ST_CMD8: begin
                if (cmd_resp == 8'h01) begin
                    done_next_s = ST_CMD55;
                end else begin
                    done_code_s = ERR_CMD8;
                end
            end
            ST_CMD55: begin
                if ((cmd_resp == 8'h00) || (cmd_resp == 8'h01)) begin
                    done_next_s = ST_ACMD41;
                end else begin
                    done_code_s = ERR_ACMD41;
                end
            end
            ST_ACMD41: begin
                if (cmd_resp == 8'h00) begin
                    done_next_s = ST_CMD16;
                end else if ((cmd_resp == 8'h01) && (pair_cnt_r != PAIR_LAST)) begin
                    done_next_s = ST_CMD55;
                end else begin
                    done_code_s = ERR_ACMD41;
                end
            end
            ST_CMD16: begin
                if (cmd_resp == 8'h00) begin
                    done_next_s = ST_READY;
                end else begin
                    done_code_s = ERR_CMD16;
                end
            end
            ST_READ: begin
                if (cmd_resp == 8'h00) begin
                    done_next_s = ST_READY;
                end else begin
                    done_code_s = ERR_READ;
                end
            end
            default: begin
                done_next_s = ST_ERROR;
                done_code_s = ERR_NONE;
            end
        endcase
    end

    // Sequencer: state, counters and all registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            timer_r    <= 16'd0;
            wd_cnt_r   <= 16'd0;
            cmd0_cnt_r <= 8'd0;
            pair_cnt_r <= 8'd0;
            addr_r     <= 32'd0;
            ready      <= 1'b0;
            busy       <= 1'b0;
            error      <= 1'b0;
            error_code <= 4'd0;
            read_data  <= 32'd0;
            read_valid <= 1'b0;
            cs_n       <= 1'b1;
            cmd_number <= 8'd0;
            cmd_args   <= 32'd0;
            cmd_crc    <= 8'd0;
            cmd_start  <= 1'b0;
        end else begin
            read_valid <= 1'b0;
            case (state_r)
                ST_IDLE, ST_ERROR: begin
                    if (init_start) begin
                        state_r    <= ST_POWERUP;
                        busy       <= 1'b1;
                        ready      <= 1'b0;
                        error      <= 1'b0;
                        error_code <= 4'd0;
                        cs_n       <= 1'b1;
                        cmd_start  <= 1'b0;
                        timer_r    <= 16'd0;
                        wd_cnt_r   <= 16'd0;
                        cmd0_cnt_r <= 8'd0;
                        pair_cnt_r <= 8'd0;
                    end
                end
                ST_POWERUP: begin
                    if (timer_r == PU_LAST) begin
                        cs_n    <= 1'b0;
                        state_r <= ST_CMD0;
                        timer_r <= 16'd0;
                        {cmd_number, cmd_args, cmd_crc} <= cmd_fields(ST_CMD0, addr_r);
                    end else begin
                        timer_r <= timer_r + 16'd1;
                    end
                end
                ST_READY: begin
                    if (read_req) begin
                        addr_r  <= read_addr;
                        state_r <= ST_READ;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                        timer_r <= 16'd0;
                        {cmd_number, cmd_args, cmd_crc} <= cmd_fields(ST_READ, read_addr);
                    end
                end
                ST_CMD0, ST_CMD8, ST_CMD55, ST_ACMD41, ST_CMD16, ST_READ: begin
                    if (!cmd_start) begin
                        // Fields were loaded on entry; hold start low for the gap first
                        if (timer_r == GAP_LAST) begin
                            cmd_start <= 1'b1;
                            wd_cnt_r  <= 16'd0;
                        end else begin
                            timer_r <= timer_r + 16'd1;
                        end
                    end else if (wd_cnt_r == WD_LAST) begin
                        // Watchdog wins over a completion on the same edge
                        state_r    <= ST_ERROR;
                        error      <= 1'b1;
                        error_code <= ERR_TIMEOUT;
                        busy       <= 1'b0;
                        ready      <= 1'b0;
                        cs_n       <= 1'b1;
                        cmd_start  <= 1'b0;
                    end else if (cmd_done) begin
                        cmd_start <= 1'b0;
                        timer_r   <= 16'd0;
                        if (done_next_s == ST_ERROR) begin
                            state_r    <= ST_ERROR;
                            error      <= 1'b1;
                            error_code <= done_code_s;
                            busy       <= 1'b0;
                            ready      <= 1'b0;
                            cs_n       <= 1'b1;
                        end else begin
                            state_r <= done_next_s;
                            {cmd_number, cmd_args, cmd_crc} <= cmd_fields(done_next_s, addr_r);
                            if (state_r == ST_CMD0) begin
                                cmd0_cnt_r <= cmd0_cnt_r + 8'd1;
                            end
                            if (state_r == ST_ACMD41) begin
                                pair_cnt_r <= pair_cnt_r + 8'd1;
                            end
                            if (state_r == ST_READ) begin
                                read_data  <= cmd_data;
                                read_valid <= 1'b1;
                            end
                            if (done_next_s == ST_READY) begin
                                ready <= 1'b1;
                                busy  <= 1'b0;
                            end
                        end
                    end else begin
                        wd_cnt_r <= wd_cnt_r + 16'd1;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a quiet, deselected idle
                    state_r   <= ST_IDLE;
                    ready     <= 1'b0;
                    busy      <= 1'b0;
                    cs_n      <= 1'b1;
                    cmd_start <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_init_seq.sv
// Self-checking bench for sd_init_seq: engine model, spec-level command
// sequence model, handshake monitor and directed/randomised scenarios.
module tb_sd_init_seq;
    localparam int GAP     = 4;
    localparam int TIMEOUT = 2048;
    localparam int PU      = 80;

    logic        clk = 1'b0;
    logic        reset, init_start, read_req;
    logic [31:0] read_addr;
    logic        ready, busy, error, read_valid, cs_n, cmd_start;
    logic [3:0]  error_code;
    logic [31:0] read_data, cmd_args, cmd_data;
    logic [7:0]  cmd_number, cmd_crc, cmd_resp;
    logic        cmd_done;

    sd_init_seq dut (
        .clk(clk), .reset(reset), .init_start(init_start), .read_req(read_req),
        .read_addr(read_addr), .ready(ready), .busy(busy), .error(error),
        .error_code(error_code), .read_data(read_data), .read_valid(read_valid),
        .cs_n(cs_n), .cmd_number(cmd_number), .cmd_args(cmd_args), .cmd_crc(cmd_crc),
        .cmd_start(cmd_start), .cmd_done(cmd_done), .cmd_resp(cmd_resp), .cmd_data(cmd_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [47:0] log_q[$];
    logic [47:0] exp_q[$];
    logic [7:0]  resp_q[$];
    logic [7:0]  def_resp = 8'hFF;
    logic [31:0] eng_data = 32'h0;
    logic [7:0]  hang_cmd = 8'h00;
    int          lat_max = 5;
    int unsigned start_cyc = 0;
    int gap_viol = 0, stab_viol = 0, rv_count = 0, rv_viol = 0;

    // Command table as the card protocol defines it
    function automatic logic [47:0] spec_fields(input logic [7:0] num, input logic [31:0] arg);
        case (num)
            8'h40:   return {8'h40, 32'h0000_0000, 8'h95};
            8'h48:   return {8'h48, 32'h0000_01AA, 8'h87};
            8'h77:   return {8'h77, 32'h0000_0000, 8'hFF};
            8'h69:   return {8'h69, 32'h4000_0000, 8'hFF};
            8'h50:   return {8'h50, 32'h0000_0004, 8'hFF};
            default: return {num, arg, 8'hFF};
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic cond(input int which);
        case (which)
            0:       return ready;
            1:       return error;
            2:       return !cs_n;
            3:       return cmd_start && (cmd_number == 8'h69);
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int which, input int budget, input string tag);
        int n;
        n = 0;
        while (n < budget && !cond(which)) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, 64'(cond(which)), 64'd1);
    endtask

    // Engine model: logs each command at cmd_start rise, answers after a random latency
    initial begin : engine
        bit active;
        int cnt;
        cmd_done = 1'b0; cmd_resp = 8'h00; cmd_data = 32'h0;
        active = 1'b0; cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (cmd_done) begin
                cmd_done = 1'b0;
                active = 1'b0;
            end else if (!cmd_start) begin
                active = 1'b0;
            end else if (!active) begin
                active = 1'b1;
                log_q.push_back({cmd_number, cmd_args, cmd_crc});
                start_cyc = cyc;
                cnt = int'($urandom_range(lat_max, 1));
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0 && cmd_number != hang_cmd) begin
                    cmd_resp = (resp_q.size() > 0) ? resp_q.pop_front() : def_resp;
                    cmd_data = eng_data;
                    cmd_done = 1'b1;
                end
            end
        end
    end

    // Handshake monitor: start gap, field stability, read_valid pulses
    initial begin : mon
        logic        prev_start;
        logic [47:0] prev_f;
        int          low_run;
        prev_start = 1'b0; prev_f = 48'h0; low_run = 1000;
        forever begin
            @(negedge clk);
            if (cmd_start && !prev_start) begin
                if (low_run < GAP) gap_viol++;
                if ({cmd_number, cmd_args, cmd_crc} !== prev_f) stab_viol++;
            end
            if (cmd_start && prev_start && ({cmd_number, cmd_args, cmd_crc} !== prev_f)) stab_viol++;
            if (cmd_start) low_run = 0; else low_run++;
            if (read_valid) begin
                rv_count++;
                if (!ready) rv_viol++;
            end
            prev_start = cmd_start;
            prev_f = {cmd_number, cmd_args, cmd_crc};
        end
    end

    initial begin : global_guard
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        resp_q.delete(); log_q.delete();
        hang_cmd = 8'h00; def_resp = 8'hFF;
        @(posedge clk); #1;
    endtask

    task automatic pulse_init();
        init_start = 1'b1;
        @(posedge clk); #1;
        init_start = 1'b0;
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_count"}, 64'(log_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            check($sformatf("%s_cmd%0d", tag, i), 64'(log_q[i]), 64'(exp_q[i]));
    endtask

    // Build the script from the protocol rules, run init, check window and order
    task automatic run_init(input int n0, input int n1, input string tag);
        int unsigned t0;
        exp_q.delete(); resp_q.delete(); log_q.delete();
        for (int i = 0; i < n0; i++) begin
            logic [7:0] b;
            b = 8'($urandom_range(255, 0));
            if (b == 8'h01) b = 8'hFF;
            resp_q.push_back(b);
            exp_q.push_back(spec_fields(8'h40, 32'h0));
        end
        exp_q.push_back(spec_fields(8'h40, 32'h0)); resp_q.push_back(8'h01);
        exp_q.push_back(spec_fields(8'h48, 32'h0)); resp_q.push_back(8'h01);
        for (int p = 0; p <= n1; p++) begin
            exp_q.push_back(spec_fields(8'h77, 32'h0));
            resp_q.push_back(($urandom_range(1, 0) == 0) ? 8'h00 : 8'h01);
            exp_q.push_back(spec_fields(8'h69, 32'h0));
            resp_q.push_back((p < n1) ? 8'h01 : 8'h00);
        end
        exp_q.push_back(spec_fields(8'h50, 32'h0)); resp_q.push_back(8'h00);
        pulse_init();
        t0 = cyc;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        wait_for(2, 300, {tag, "_cs_low"});
        check({tag, "_cs_window"}, 64'(cyc - t0), 64'(PU));
        wait_for(0, 8000, {tag, "_ready"});
        check({tag, "_busy_idle"}, 64'(busy), 64'd0);
        check({tag, "_err"}, 64'(error), 64'd0);
        compare_log(tag);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] data, input logic [7:0] resp, input string tag);
        int rv0;
        log_q.delete(); resp_q.delete();
        resp_q.push_back(resp);
        eng_data = data;
        rv0 = rv_count;
        read_addr = addr; read_req = 1'b1;
        @(posedge clk); #1;
        read_req = 1'b0; read_addr = $urandom();
        check({tag, "_ready_drop"}, 64'(ready), 64'd0);
        if (resp == 8'h00) begin
            wait_for(0, 500, {tag, "_done"});
            check({tag, "_valid_with_ready"}, 64'(read_valid), 64'd1);
            check({tag, "_data"}, 64'(read_data), 64'(data));
            @(posedge clk); #1;
            check({tag, "_valid_low"}, 64'(read_valid), 64'd0);
            check({tag, "_one_pulse"}, 64'(rv_count - rv0), 64'd1);
        end else begin
            wait_for(1, 500, {tag, "_err"});
            check({tag, "_code"}, 64'(error_code), 64'd5);
            check({tag, "_cs_high"}, 64'(cs_n), 64'd1);
            check({tag, "_no_valid"}, 64'(rv_count - rv0), 64'd0);
        end
        check({tag, "_ncmd"}, 64'(log_q.size()), 64'd1);
        if (log_q.size() > 0) check({tag, "_fields"}, 64'(log_q[0]), 64'(spec_fields(8'h51, addr)));
    endtask

    initial begin : main
        int rv0;
        reset = 1'b1; init_start = 1'b0; read_req = 1'b0; read_addr = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_flags", 64'({ready, busy, error, read_valid, cmd_start}), 64'd0);
        check("rst_cs_n", 64'(cs_n), 64'd1);
        check("rst_fields", 64'({error_code, read_data, cmd_number, cmd_args, cmd_crc}), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // read_req in IDLE is dropped
        read_addr = 32'h55; read_req = 1'b1;
        @(posedge clk); #1;
        read_req = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("idle_read_dropped", 64'(log_q.size()), 64'd0);
        check("idle_not_ready", 64'({ready, busy}), 64'd0);

        // Nominal init: ACMD41 busy twice, then ready
        lat_max = 5;
        run_init(0, 2, "nominal");

        do_read(32'h0000_1234, 32'hDEAD_BEEF, 8'h00, "read_spec");
        for (int i = 0; i < 3; i++)
            do_read($urandom(), $urandom(), 8'h00, $sformatf("read_rnd%0d", i));

        // init_start in READY is ignored
        log_q.delete();
        pulse_init();
        repeat (100) @(posedge clk);
        #1;
        check("ready_init_ignored", 64'(log_q.size()), 64'd0);
        check("ready_still", 64'({ready, cs_n}), 64'b10);

        // Failed read, then read_req in ERROR is dropped
        do_read($urandom(), $urandom(), 8'h04, "read_bad");
        log_q.delete();
        read_req = 1'b1;
        @(posedge clk); #1;
        read_req = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("err_read_dropped", 64'(log_q.size()), 64'd0);

        // Init from ERROR, then randomised scripts after reset
        run_init(1, 0, "from_err");
        for (int k = 0; k < 3; k++) begin
            do_reset();
            lat_max = int'($urandom_range(8, 1));
            run_init(int'($urandom_range(3, 0)), int'($urandom_range(4, 0)), $sformatf("rnd%0d", k));
        end

        // CMD0 never answers 0x01
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(spec_fields(8'h40, 32'h0));
        pulse_init();
        wait_for(1, 3000, "cmd0_err");
        check("cmd0_code", 64'(error_code), 64'd1);
        check("cmd0_outs", 64'({cs_n, busy, ready, cmd_start}), 64'b1000);
        compare_log("cmd0");

        // Watchdog during CMD8
        do_reset();
        hang_cmd = 8'h48;
        resp_q.push_back(8'h01);
        pulse_init();
        wait_for(1, 5000, "wd_err");
        check("wd_code", 64'(error_code), 64'd6);
        check("wd_latency", 64'(cyc - start_cyc), 64'(TIMEOUT));
        check("wd_last_cmd", 64'(log_q[log_q.size() - 1]), 64'(spec_fields(8'h48, 32'h0)));
        check("wd_outs", 64'({cs_n, cmd_start}), 64'b10);

        // ACMD41 never leaves idle: 255 pairs then code 3
        do_reset();
        def_resp = 8'h01;
        lat_max = 2;
        pulse_init();
        wait_for(1, 30000, "acmd_err");
        check("acmd_code", 64'(error_code), 64'd3);
        check("acmd_ncmd", 64'(log_q.size()), 64'd512);
        check("acmd_last", 64'(log_q[log_q.size() - 1]), 64'(spec_fields(8'h69, 32'h0)));

        // Reset in the middle of ACMD41
        do_reset();
        lat_max = 4;
        hang_cmd = 8'h69;
        resp_q.push_back(8'h01); resp_q.push_back(8'h01); resp_q.push_back(8'h01);
        pulse_init();
        wait_for(3, 2000, "mid_acmd");
        rv0 = rv_count;
        #3;
        reset = 1'b1;
        #1;
        check("async_start", 64'(cmd_start), 64'd0);
        check("async_cs_n", 64'(cs_n), 64'd1);
        check("async_flags", 64'({ready, busy, error, read_valid, cmd_number}), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        hang_cmd = 8'h00;
        @(posedge clk); #1;
        check("async_no_valid", 64'(rv_count - rv0), 64'd0);
        run_init(0, 1, "rerun");

        check("gap_violations", 64'(gap_viol), 64'd0);
        check("field_violations", 64'(stab_viol), 64'd0);
        check("valid_without_ready", 64'(rv_viol), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sd_init_seq.md
# sd_init_seq

Command sequencer directly upstream of the `sd_cmd` SPI-mode command engine. It runs the SD card power-up and initialisation sequence (CMD0, CMD8, CMD55/ACMD41 loop, CMD16), then serves single-word read requests with CMD17. It drives `sd_cmd`'s command fields and `start`, and consumes its `done`, `response_flags` and `data_transmission` outputs. It exposes a simple ready/request/valid interface to the rest of the design.

## Interface
- POWERUP_CYCLES, 80: cycles with `cs_n` high before the first command.
- GAP_CYCLES, 4: minimum cycles with `cmd_start` low between commands (≥2).
- CMD_TIMEOUT, 2048: per-command watchdog, in cycles from `cmd_start` rise.
- CMD0_RETRIES, 8: CMD0 attempts before error.
- ACMD41_RETRIES, 255: CMD55+ACMD41 pairs before error.

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- init_start  in  1  pulse; begin (or restart) initialisation
- read_req  in  1  pulse; request a read, honoured only while `ready`=1
- read_addr  in  32  CMD17 argument, sampled with `read_req`
- ready  out  1  init complete, idle, accepting `read_req`
- busy  out  1  sequence or read in progress
- error  out  1  sticky failure flag
- error_code  out  4  failure cause, valid while `error`=1
- read_data  out  32  last read word
- read_valid  out  1  one-cycle pulse, `read_data` valid
- cs_n  out  1  card chip select, active-low
- cmd_number  out  8  command byte, already ORed with 0x40
- cmd_args  out  32  command argument
- cmd_crc  out  8  CRC byte
- cmd_start  out  1  held high for the whole command; low resets the engine
- cmd_done  in  1  engine completion, either data or internal timeout
- cmd_resp  in  8  engine `response_flags`
- cmd_data  in  32  engine `data_transmission`

## Operation
- Reset values: all outputs 0, except `cs_n`=1. The state machine enters IDLE and all counters clear.
- States: IDLE → POWERUP → CMD0 → CMD8 → CMD55 → ACMD41 → CMD16 → READY ⇄ READ. Any state can go to ERROR.
- IDLE: waits for `init_start`. On `init_start`: `busy`=1, clear `error`/`error_code`, enter POWERUP.
- POWERUP: `cs_n`=1 for POWERUP_CYCLES, then `cs_n`=0 for the rest of the operation.
- Command fields by state:
  - CMD0: 0x40, 0x00000000, 0x95. Requires resp 0x01. Otherwise retry; after CMD0_RETRIES attempts, ERROR with code 1.
  - CMD8: 0x48, 0x000001AA, 0x87. Requires resp 0x01, otherwise code 2.
  - CMD55: 0x77, 0, 0xFF. Resp must be 0x00 or 0x01, otherwise code 3.
  - ACMD41: 0x69, 0x40000000, 0xFF. Resp 0x00 → CMD16. Resp 0x01 → back to CMD55 and increment the pair count. After ACMD41_RETRIES pairs, code 3. Any other resp → code 3.
  - CMD16: 0x50, 0x00000004, 0xFF. Requires resp 0x00, otherwise code 4.
  - READ: 0x51, latched `read_addr`, 0xFF. Resp 0x00 → `read_data`←`cmd_data`, `read_valid` pulse, return to READY. Otherwise code 5.
- Watchdog: `cmd_done` absent for CMD_TIMEOUT cycles → ERROR with code 6. This takes priority over a `cmd_done` arriving on the same cycle.
- READY: `ready`=1, `busy`=0. `read_req` latches `read_addr`, sets `ready`=0 and enters READ.
- ERROR: `error`=1, `busy`=0, `ready`=0, `cs_n`=1. Only `init_start` (→ POWERUP) or `reset` exits.
- `init_start` while busy or in READY: ignored. `read_req` outside READY: dropped, no response.

## Timing
- Command issue:
  - Fields are registered on state entry and are stable one cycle before `cmd_start` rises.
  - Fields are held constant while `cmd_start`=1.
- Completion:
  - `cmd_resp`/`cmd_data` are sampled on the first clock edge where `cmd_done`=1.
  - `cmd_start` drops on the next cycle.
  - `cmd_start` stays low for GAP_CYCLES before the next command rises.
- `read_valid` is asserted exactly one cycle, on the same cycle `ready` returns to 1.
- `reset` mid-command: `cmd_start` drops immediately (asynchronously) and `cs_n`=1. No partial `read_valid` is produced.

## Test plan
- Nominal init:
  - Engine model returns CMD0 0x01, CMD8 0x01, ACMD41 0x01 twice then 0x00, CMD16 0x00.
  - Required: exact command order CMD0, CMD8, CMD55, ACMD41 ×3 pairs, CMD16, then `ready`=1.
  - Also check the `cs_n` high window is 80 cycles.
- CMD0 failure: resp always 0xFF → 8 CMD0 attempts, then `error`=1, `error_code`=1, `cs_n`=1.
- Read: in READY, pulse `read_req` with addr 0x00001234; model returns resp 0x00 and data 0xDEADBEEF.
  - Required: cmd_number 0x51, cmd_args 0x00001234, a single `read_valid` pulse, `read_data`=0xDEADBEEF.
- Watchdog: `cmd_done` never asserted during CMD8 → ERROR with code 6 exactly CMD_TIMEOUT cycles after `cmd_start` rose.
- Handshake spacing: every `cmd_start` low gap is ≥GAP_CYCLES, and fields never change while `cmd_start`=1 (assertion over the nominal run).
- Reset mid-ACMD41: outputs return to their reset values asynchronously. A following `init_start` re-runs the full sequence from POWERUP.
